// File: rtl/sata_pkg.sv
// Shared constants, tuser layout and state encoding for the SATA command FIS builder.
package sata_pkg;

  localparam logic [7:0] FIS_TYPE_REG_H2D = 8'h27;
  localparam logic [7:0] FIS_TYPE_DATA    = 8'h46;
  localparam logic [7:0] ATA_CMD_READ     = 8'h25;
  localparam logic [7:0] ATA_CMD_WRITE    = 8'h35;

  // tuser = {drop, err, keep[3:0], sop, eop}
  localparam int TU_EOP      = 0;
  localparam int TU_SOP      = 1;
  localparam int TU_KEEP_LSB = 2;
  localparam int TU_ERR      = 6;
  localparam int TU_DROP     = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFIS = 3'd1,
    ST_DHDR = 3'd2,
    ST_DATA = 3'd3,
    ST_ACK  = 3'd4
  } fis_state_t;

  function automatic logic [7:0] mk_tuser(input logic sop, input logic eop);
    logic [7:0] u;
    u                    = '0;
    u[TU_DROP]           = 1'b0;
    u[TU_ERR]            = 1'b0;
    u[TU_KEEP_LSB +: 4]  = 4'hF;
    u[TU_SOP]            = sop;
    u[TU_EOP]            = eop;
    return u;
  endfunction

  // Register H2D FIS dword idx for a latched command word
  function automatic logic [31:0] cfis_word(input logic [2:0] idx, input logic wr,
                                            input logic [63:0] cmd);
    case (idx)
      3'd0:    return {8'h00, (wr ? ATA_CMD_WRITE : ATA_CMD_READ), 8'h80, FIS_TYPE_REG_H2D};
      3'd1:    return {8'h40, cmd[23:0]};
      3'd2:    return {8'h00, cmd[47:24]};
      3'd3:    return {16'h0000, cmd[63:48]};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sata_cmd_fis_if.sv
// 32-bit dword stream with 8-bit sideband, shared by the payload input and FIS output.
interface sata_cmd_fis_if;
  logic [31:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tvalid, input  tready);
  modport slave  (input  tdata, input  tuser, input  tvalid, output tready);
endinterface

// File: rtl/sata_cmd_fis_stat.sv
// Optional activity counters; the module only exists when SATA_CMD_FIS_STAT_EN is defined.
`ifdef SATA_CMD_FIS_STAT_EN
module sata_cmd_fis_stat (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_done,
  input  logic        dw_beat,
  input  logic        eop_beat,
  output logic [31:0] stat_cmd_cnt,
  output logic [31:0] stat_dw_cnt,
  output logic [31:0] stat_fis_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmd_cnt <= '0;
      stat_dw_cnt  <= '0;
      stat_fis_cnt <= '0;
    end else begin
      if (cmd_done) stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
      if (dw_beat)  stat_dw_cnt  <= stat_dw_cnt + 32'd1;
      if (eop_beat) stat_fis_cnt <= stat_fis_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/sata_cmd_fis.sv
// Turns a 64-bit LBA/count command into a Register H2D FIS plus, for writes, chunked Data FIS.
// Define SATA_CMD_FIS_STAT_EN to add the stat_* counter ports.
//
// state | meaning
// IDLE  | waiting for cmd_req, command latched on accept
// CFIS  | emitting the 5-dword Register H2D FIS from registers
// DHDR  | emitting the single-dword Data FIS header
// DATA  | payload passes through combinationally, chunk/remaining counters run
// ACK   | one-cycle cmd_ack, cmd_req ignored
module sata_cmd_fis
  import sata_pkg::*;
#(
  parameter int MAX_FIS_DW = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   cmd_dat,
  input  logic          cmd_wr,
  input  logic          cmd_req,
  output logic          cmd_ack,
  sata_cmd_fis_if.slave  s_axis_sbt,
  sata_cmd_fis_if.master m_axis_fis,
  output logic          busy
`ifdef SATA_CMD_FIS_STAT_EN
  ,
  output logic [31:0]   stat_cmd_cnt,
  output logic [31:0]   stat_dw_cnt,
  output logic [31:0]   stat_fis_cnt
`endif
);

  localparam int CW = $clog2(MAX_FIS_DW + 1);

  fis_state_t     state;
  logic [63:0]    cmd_q;
  logic           wr_q;
  logic [2:0]     idx_q;
  logic [23:0]    rem_q;
  logic [CW-1:0]  chunk_q;
  logic           vld_q;
  logic [31:0]    dat_q;
  logic [7:0]     usr_q;

  logic           in_data;
  logic           m_fire;
  logic           s_fire;
  logic           chunk_last;
  logic           rem_last;
  logic [CW-1:0]  chunk_nxt;
  logic           unused_in_tuser;

  assign in_data    = (state == ST_DATA);
  assign chunk_last = (chunk_q == CW'(1));
  assign rem_last   = (rem_q == 24'd1);
  assign chunk_nxt  = (rem_q > 24'(MAX_FIS_DW)) ? CW'(MAX_FIS_DW) : rem_q[CW-1:0];

  // Payload framing comes only from the dword count, so the input sideband is not consumed.
  assign unused_in_tuser = ^s_axis_sbt.tuser;

  assign m_axis_fis.tvalid = in_data ? s_axis_sbt.tvalid : vld_q;
  assign m_axis_fis.tdata  = in_data ? s_axis_sbt.tdata  : dat_q;
  assign m_axis_fis.tuser  = in_data ? mk_tuser(1'b0, chunk_last) : usr_q;
  assign s_axis_sbt.tready = in_data & m_axis_fis.tready;

  assign m_fire = m_axis_fis.tvalid & m_axis_fis.tready;
  assign s_fire = in_data & s_axis_sbt.tvalid & m_axis_fis.tready;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      usr_q   <= '0;
      cmd_ack <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_req) begin
            cmd_q <= cmd_dat;
            wr_q  <= cmd_wr;
            idx_q <= 3'd0;
            // sectors * 128; a zero count means 65536 sectors
            rem_q <= {(cmd_dat[63:48] == 16'd0), cmd_dat[63:48], 7'd0};
            dat_q <= cfis_word(3'd0, cmd_wr, cmd_dat);
            usr_q <= mk_tuser(1'b1, 1'b0);
            vld_q <= 1'b1;
            state <= ST_CFIS;
          end
        end
        ST_CFIS: begin
          if (m_fire) begin
            if (idx_q == 3'd4) begin
              if (wr_q) begin
                dat_q <= {24'h0, FIS_TYPE_DATA};
                usr_q <= mk_tuser(1'b1, 1'b0);
                state <= ST_DHDR;
              end else begin
                vld_q   <= 1'b0;
                dat_q   <= '0;
                usr_q   <= '0;
                cmd_ack <= 1'b1;
                state   <= ST_ACK;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              dat_q <= cfis_word(idx_q + 3'd1, wr_q, cmd_q);
              usr_q <= mk_tuser(1'b0, idx_q == 3'd3);
            end
          end
        end
        ST_DHDR: begin
          if (m_fire) begin
            vld_q   <= 1'b0;
            dat_q   <= '0;
            usr_q   <= '0;
            chunk_q <= chunk_nxt;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_fire) begin
            rem_q   <= rem_q - 24'd1;
            chunk_q <= chunk_q - CW'(1);
            if (chunk_last) begin
              if (rem_last) begin
                cmd_ack <= 1'b1;
                state   <= ST_ACK;
              end else begin
                dat_q <= {24'h0, FIS_TYPE_DATA};
                usr_q <= mk_tuser(1'b1, 1'b0);
                vld_q <= 1'b1;
                state <= ST_DHDR;
              end
            end
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SATA_CMD_FIS_STAT_EN
  sata_cmd_fis_stat u_stat (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_done     (cmd_ack),
    .dw_beat      (s_fire),
    .eop_beat     (m_fire & m_axis_fis.tuser[TU_EOP]),
    .stat_cmd_cnt (stat_cmd_cnt),
    .stat_dw_cnt  (stat_dw_cnt),
    .stat_fis_cnt (stat_fis_cnt)
  );
`endif

endmodule

// File: doc/sata_cmd_fis.md
SATA_CMD_FIS -- requirements
Module: sata_cmd_fis

Interface
REQ-001 Parameter MAX_FIS_DW, default 2048, maximum payload dwords per Data FIS; legal range 1..2048.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 cmd_dat  input  64  command word: [47:0] LBA, [63:48] sector count; count 0 means 65536 sectors.
REQ-005 cmd_wr  input  1  direction, sampled with cmd_dat: 1 = write, 0 = read.
REQ-006 cmd_req  input  1  command request level; held high until cmd_ack.
REQ-007 cmd_ack  output  1  one-cycle pulse when the command is fully emitted.
REQ-008 s_axis_sbt_tdata/tuser/tvalid/tready  in/in/in/out  32/8/1/1  write payload stream; tuser is {drop,err,keep[3:0],sop,eop}.
REQ-009 m_axis_fis_tdata/tuser/tvalid/tready  out/out/out/in  32/8/1/1  FIS stream toward the transport layer; tuser uses the same layout.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 States: IDLE, CFIS, DHDR, DATA, ACK.
REQ-012 IDLE: when cmd_req=1 and ack is not in progress, latch cmd_dat and cmd_wr, then go to CFIS on the next cycle.
REQ-013 CFIS emits the 5-dword Register H2D FIS.
  - DW0 = {8'h00, CMD, 8'h80, 8'h27}; CMD = 8'h35 for write, 8'h25 for read.
  - DW1 = {8'h40, LBA[23:0]}.
  - DW2 = {8'h00, LBA[47:24]}.
  - DW3 = {16'h0000, COUNT}.
  - DW4 = 32'h0.
REQ-014 Every output beat carries keep=4'hF and drop=err=0; sop is set on the first dword of each FIS and eop on the last.
REQ-015 Total payload dwords = sectors*128, held in a 24-bit counter; count 0 gives 8,388,608 dwords.
REQ-016 After CFIS, a read goes to ACK; a write goes to DHDR.
REQ-017 DHDR emits a single-dword Data FIS header 32'h0000_0046 with sop=1 and eop=0, then goes to DATA.
REQ-018 DATA passes s_axis_sbt_tdata through unchanged.
  - Chunk length = min(remaining, MAX_FIS_DW); eop is set on the last dword of the chunk.
  - Remaining > 0 after the chunk: go to DHDR.
  - Remaining = 0: go to ACK.
REQ-019 DATA flow control is combinational: s_axis_sbt_tready = m_axis_fis_tready in DATA and 0 elsewhere; m_axis_fis_tvalid = s_axis_sbt_tvalid in DATA.
REQ-020 Input sop/eop/keep/drop/err are ignored for framing; only the dword count defines boundaries.
REQ-021 In CFIS and DHDR, m_axis_fis_tvalid=1 from a register, and tdata/tuser stay stable until tready.
REQ-022 ACK pulses cmd_ack for one cycle, then returns to IDLE; cmd_req is not re-sampled in the ACK cycle.
REQ-023 Latency: first CFIS beat is valid 1 cycle after cmd_req is sampled high; with tready held at 1, a read acks 6 cycles after the request.
REQ-024 A new cmd_dat arriving while busy is ignored until IDLE.

Reset
REQ-025 On rst_n low, asynchronously go to IDLE and clear these to 0: cmd_ack, busy, m_axis_fis_tvalid, tdata, tuser, all counters, s_axis_sbt_tready.
REQ-026 Reset in the middle of a FIS abandons it with no eop emitted; after release, the block accepts a fresh cmd_req.

Configuration
REQ-027 With SATA_CMD_FIS_STAT_EN defined, add three 32-bit wrapping counters:
  - stat_cmd_cnt output increments on each cmd_ack.
  - stat_dw_cnt output increments on each accepted DATA beat.
  - stat_fis_cnt output increments on each emitted eop.
  - All three reset to 0.
REQ-028 Without SATA_CMD_FIS_STAT_EN, none of the three ports or counters exist and behaviour is otherwise identical.

Structure
REQ-029 Package sata_pkg holds:
  - the FIS type constants 8'h27 and 8'h46;
  - the ATA opcodes 8'h25 and 8'h35;
  - the tuser bit index constants;
  - the state enum typedef.
REQ-030 A single sub-module, sata_cmd_fis_stat, holds the optional counters; everything else is flat.

Verification
REQ-031 Read: cmd_dat=64'h0001_0000_1234_5678, cmd_wr=0, tready=1 ->
  - 5 beats: 32'h0025_8027, 32'h4034_5678, 32'h0000_0012, 32'h0000_0001, 0;
  - sop on beat 1, eop on beat 5;
  - cmd_ack 1 cycle later.
REQ-032 Write with count=1 and MAX_FIS_DW=2048 -> CFIS, then header 32'h46, then 128 payload dwords with eop on dword 128, then cmd_ack.
REQ-033 Write with count=20 and MAX_FIS_DW=2048 (2560 dwords) -> two Data FIS of 2048 and 512 dwords, each preceded by a header.
REQ-034 Random tready/tvalid gaps during a write -> output data equals input data in order; output is stable while stalled; no dwords lost or duplicated.
REQ-035 rst_n low mid-DATA -> outputs are 0 in the same cycle; after release, a read command produces a correct CFIS.
REQ-036 With SATA_CMD_FIS_STAT_EN, after REQ-031 then REQ-033 -> stat_cmd_cnt=2, stat_dw_cnt=2560, stat_fis_cnt=4.
